// File: rtl/weight_buffer_if.sv
// Handshake and data bundle between the host/array side and the weight buffer.
interface weight_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ROWS   = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                     fetch_start;
  logic [ADDR_W-1:0]        fetch_base;
  logic [ADDR_W:0]          fetch_len;
  logic [DATA_W-1:0]        host_data;
  logic                     host_valid;
  logic                     host_ready;
  logic                     fetch_busy;
  logic                     fetch_done;
  logic                     load_weight;
  logic [ADDR_W-1:0]        load_addr;
  logic [ROWS*DATA_W-1:0]   weight_out;
  logic                     weight_valid;

  modport master (
    output fetch_start, fetch_base, fetch_len, host_data, host_valid,
    output load_weight, load_addr,
    input  host_ready, fetch_busy, fetch_done, weight_out, weight_valid
  );

  modport slave (
    input  fetch_start, fetch_base, fetch_len, host_data, host_valid,
    input  load_weight, load_addr,
    output host_ready, fetch_busy, fetch_done, weight_out, weight_valid
  );
endinterface

// File: rtl/weight_buffer.sv
// Weight store for the systolic array: a fill engine writes host bytes from a
// programmable base, and an independent read port returns ROWS consecutive
// weights per request (lane k = entry load_addr+k, wrapping).
module weight_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ROWS   = 4
) (
  input  logic            clk,
  input  logic            reset,
  weight_buffer_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      ptr_q;
  logic [ADDR_W:0]        len_q;
  logic [ADDR_W:0]        cnt_q;
  logic [ADDR_W:0]        len_clamped;
  logic                   wr_en;
  logic [DATA_W-1:0]      mem [DEPTH];
  logic [ROWS*DATA_W-1:0] weight_p1;
  logic                   vld_p1;

  // A burst can never be longer than the buffer itself.
  assign len_clamped = (bus.fetch_len > DEPTH_L) ? DEPTH_L : bus.fetch_len;
  assign wr_en       = (state_q == FILL) && bus.host_valid;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a zero-length burst completes without visiting FILL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.fetch_start) state_d = (len_clamped == '0) ? DONE : FILL;
      FILL: if (wr_en && ((cnt_q + (ADDR_W+1)'(1)) == len_q)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    bus.host_ready = (state_q == FILL);
    bus.fetch_busy = (state_q == FILL);
    bus.fetch_done = (state_q == DONE);
  end

  // Burst pointer, length and progress count; the pointer wraps modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else if ((state_q == IDLE) && bus.fetch_start) begin
      ptr_q <= bus.fetch_base;
      len_q <= len_clamped;
      cnt_q <= '0;
    end else if (wr_en) begin
      ptr_q <= ptr_q + ADDR_W'(1);
      cnt_q <= cnt_q + (ADDR_W+1)'(1);
    end
  end

  // Weight storage; reset clears every entry so reads after reset return zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[ptr_q] <= bus.host_data;
    end
  end

  // ---- read stage p1: registered lanes; a same-edge write is not forwarded ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= bus.load_weight;
      if (bus.load_weight) begin
        for (int k = 0; k < ROWS; k++)
          weight_p1[k*DATA_W +: DATA_W] <= mem[bus.load_addr + ADDR_W'(k)];
      end
    end
  end

  assign bus.weight_out   = weight_p1;
  assign bus.weight_valid = vld_p1;
endmodule

// File: tb/tb_weight_buffer.sv
// Bench for weight_buffer: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a behavioural model.
module tb_weight_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
  localparam int ROWS   = 4;

  logic clk;
  logic reset;

  weight_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ROWS(ROWS)) bus ();

  weight_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ROWS(ROWS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: memory contents plus burst progress.
  int          mem_m [DEPTH];
  bit          m_active;
  bit          m_done;
  int          m_left;
  int          m_addr;
  logic [31:0] exp_w;
  bit          exp_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.fetch_start = 0; bus.fetch_base = '0; bus.fetch_len = '0;
    bus.host_data = '0; bus.host_valid = 0; bus.load_weight = 0; bus.load_addr = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
    m_active = 0; m_done = 0; m_left = 0; m_addr = 0;
    exp_w = '0; exp_v = 0;
  endtask

  // Apply current inputs for one clock, advance the model, compare after the edge.
  task automatic tick();
    logic [31:0] nw;
    bit nv;
    int len;
    nw = exp_w; nv = 0;
    if (bus.load_weight) begin
      nv = 1;
      for (int k = 0; k < ROWS; k++)
        nw[k*8 +: 8] = 8'(mem_m[(int'(bus.load_addr) + k) % DEPTH]);
    end
    if (m_active) begin
      if (bus.host_valid) begin
        mem_m[m_addr] = int'(bus.host_data);
        m_addr = (m_addr + 1) % DEPTH;
        m_left--;
        if (m_left == 0) begin m_active = 0; m_done = 1; end
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (bus.fetch_start) begin
      len = int'(bus.fetch_len);
      m_left = (len > DEPTH) ? DEPTH : len;
      m_addr = int'(bus.fetch_base);
      if (m_left == 0) m_done = 1; else m_active = 1;
    end
    exp_w = nw; exp_v = nv;
    @(posedge clk); #1;
    chk("host_ready",   32'(bus.host_ready),   32'(m_active));
    chk("fetch_busy",   32'(bus.fetch_busy),   32'(m_active));
    chk("fetch_done",   32'(bus.fetch_done),   32'(m_done));
    chk("weight_valid", 32'(bus.weight_valid), 32'(exp_v));
    chk("weight_out",   bus.weight_out,        exp_w);
  endtask

  task automatic do_reset();
    reset = 1;
    #3;
    model_clear();
    chk("rst_host_ready",   32'(bus.host_ready),   32'd0);
    chk("rst_fetch_done",   32'(bus.fetch_done),   32'd0);
    chk("rst_weight_valid", 32'(bus.weight_valid), 32'd0);
    chk("rst_weight_out",   bus.weight_out,        32'd0);
    reset = 0;
  endtask

  task automatic start(input int base, input int len);
    bus.fetch_start = 1; bus.fetch_base = 6'(base); bus.fetch_len = 7'(len);
    tick();
    bus.fetch_start = 0;
  endtask

  task automatic send(input int data);
    bus.host_valid = 1; bus.host_data = 8'(data);
    tick();
    bus.host_valid = 0;
  endtask

  task automatic read(input int addr);
    bus.load_weight = 1; bus.load_addr = 6'(addr);
    tick();
    bus.load_weight = 0;
  endtask

  typedef struct {
    bit          start;
    int          base;
    int          len;
    bit          valid;
    int          data;
    bit          load;
    int          addr;
    bit          e_ready;
    bit          e_done;
    bit          e_wvalid;
    logic [31:0] e_wout;
  } vec_t;

  vec_t tbl [8];

  initial begin
    // Reset read, then a 4-byte burst at base 0 and a read-back.
    tbl[0] = '{0, 0, 0, 0, 0,    1, 0, 0, 0, 1, 32'h0000_0000};
    tbl[1] = '{1, 0, 4, 0, 0,    0, 0, 1, 0, 0, 32'h0000_0000};
    tbl[2] = '{0, 0, 0, 1, 11,   0, 0, 1, 0, 0, 32'h0000_0000};
    tbl[3] = '{0, 0, 0, 1, 22,   0, 0, 1, 0, 0, 32'h0000_0000};
    tbl[4] = '{0, 0, 0, 1, 33,   0, 0, 1, 0, 0, 32'h0000_0000};
    tbl[5] = '{0, 0, 0, 1, 44,   0, 0, 0, 1, 0, 32'h0000_0000};
    tbl[6] = '{0, 0, 0, 0, 0,    1, 0, 0, 0, 1, 32'h2C21_160B};
    tbl[7] = '{0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 32'h2C21_160B};

    idle_inputs();
    reset = 0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      bus.fetch_start = tbl[i].start; bus.fetch_base = 6'(tbl[i].base);
      bus.fetch_len = 7'(tbl[i].len); bus.host_valid = tbl[i].valid;
      bus.host_data = 8'(tbl[i].data); bus.load_weight = tbl[i].load;
      bus.load_addr = 6'(tbl[i].addr);
      tick();
      chk("tbl_ready",  32'(bus.host_ready),   32'(tbl[i].e_ready));
      chk("tbl_done",   32'(bus.fetch_done),   32'(tbl[i].e_done));
      chk("tbl_wvalid", 32'(bus.weight_valid), 32'(tbl[i].e_wvalid));
      chk("tbl_wout",   bus.weight_out,        tbl[i].e_wout);
    end
    idle_inputs();

    // Burst wrapping past the top of memory.
    start(62, 4);
    for (int i = 1; i <= 4; i++) send(i);
    chk("wrap_done", 32'(bus.fetch_done), 32'd1);
    read(62);
    chk("wrap_read62", bus.weight_out, 32'h0403_0201);
    read(0);
    chk("wrap_read0", bus.weight_out, 32'h2C21_0403);

    // Stalls between bytes and an ignored fetch_start mid-burst.
    start(10, 3);
    send(8'h51);
    for (int i = 0; i < 3; i++) tick();
    chk("stall_ready", 32'(bus.host_ready), 32'd1);
    bus.fetch_start = 1; bus.fetch_base = 6'd40; bus.fetch_len = 7'd1;
    tick();
    bus.fetch_start = 0;
    send(8'h52);
    send(8'h53);
    chk("stall_done", 32'(bus.fetch_done), 32'd1);
    read(10);
    chk("stall_read10", bus.weight_out, 32'h0053_5251);
    read(40);
    chk("ignored_start_read40", bus.weight_out, 32'h0000_0000);

    // Largest representable length clamps to a full-buffer burst.
    start(20, 127);
    for (int i = 0; i < 63; i++) send(100 + i);
    chk("clamp_not_done", 32'(bus.fetch_done), 32'd0);
    send(163);
    chk("clamp_done", 32'(bus.fetch_done), 32'd1);
    tick();
    chk("clamp_idle", 32'(bus.host_ready), 32'd0);
    read(20);
    chk("clamp_read20", bus.weight_out, 32'h6766_6564);

    // Zero-length burst: done pulse without any writes.
    start(0, 0);
    chk("zero_done", 32'(bus.fetch_done), 32'd1);
    tick();
    chk("zero_done_clear", 32'(bus.fetch_done), 32'd0);

    // Reset in the middle of a burst.
    start(0, 8);
    send(1); send(2); send(3);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(bus.fetch_done), 32'd0);
    end
    read(0);
    chk("abort_mem_clear", bus.weight_out, 32'h0000_0000);

    // Read and write of the same entry at the same edge.
    start(5, 1);
    bus.host_valid = 1; bus.host_data = 8'hAA;
    bus.load_weight = 1; bus.load_addr = 6'd5;
    tick();
    idle_inputs();
    chk("rw_old_value", bus.weight_out, 32'h0000_0000);
    read(5);
    chk("rw_new_value", bus.weight_out, 32'h0000_00AA);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      int r;
      idle_inputs();
      if (!m_active && !m_done && ($urandom_range(0, 3) == 0)) begin
        r = $urandom_range(0, 9);
        bus.fetch_start = 1;
        bus.fetch_base  = 6'($urandom_range(0, DEPTH - 1));
        bus.fetch_len   = (r == 0) ? 7'd0 : (r == 1) ? 7'($urandom_range(65, 127))
                                                     : 7'($urandom_range(1, 12));
      end
      if ($urandom_range(0, 9) < 6) begin
        bus.host_valid = 1;
        bus.host_data  = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 1) == 1) begin
        bus.load_weight = 1;
        bus.load_addr   = 6'($urandom_range(0, DEPTH - 1));
      end
      tick();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
